tlb_op_ctrl: RTL and testbench

Sequencer for TLB maintenance instructions (TLBRD, TLBWR, TLBFILL, INVTLB) retiring in the WB stage. It owns the TLB read and write ports on behalf of WB. It runs single-entry operations in one execute cycle and INVTLB as a multi-cycle sweep over all entries. It also supplies the TLBFILL victim index and signals completion back to WB, which holds the instruction until `op_done`.

---
 rtl/tlb_op_ctrl_if.sv | 46 ++++
 rtl/tlb_op_ctrl.sv | 164 ++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_ctrl_if.sv
// rtl/tlb_op_ctrl_if.sv - WB-side op request/completion and TLB read/write port bundle
//
// Purpose: groups every non-clock/reset signal of tlb_op_ctrl.
//   slave  modport: the sequencer (takes ops, drives TLB ports)
//   master modport: the WB stage / TLB array side
// Signals:
//   op_valid, op_type[1:0], inv_op[4:0], inv_asid[9:0], inv_vppn[18:0], csr_index  - op request
//   busy, op_done, refetch_req                                                     - op status
//   r_index, r_e, r_g, r_asid[9:0], r_vppn[18:0], r_ps[5:0]                        - TLB read port
//   csr_tlbrd_we                                                                   - CSR latch strobe for TLBRD
//   we, w_index, w_clr                                                             - TLB write port
interface tlb_op_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             op_valid;
  logic [1:0]       op_type;
  logic [4:0]       inv_op;
  logic [9:0]       inv_asid;
  logic [18:0]      inv_vppn;
  logic [IDX_W-1:0] csr_index;
  logic             busy;
  logic             op_done;
  logic             refetch_req;
  logic [IDX_W-1:0] r_index;
  logic             r_e;
  logic             r_g;
  logic [9:0]       r_asid;
  logic [18:0]      r_vppn;
  logic [5:0]       r_ps;
  logic             csr_tlbrd_we;
  logic             we;
  logic [IDX_W-1:0] w_index;
  logic             w_clr;

  modport slave (
    input  op_valid, op_type, inv_op, inv_asid, inv_vppn, csr_index,
    input  r_e, r_g, r_asid, r_vppn, r_ps,
    output busy, op_done, refetch_req, r_index, csr_tlbrd_we, we, w_index, w_clr
  );

  modport master (
    output op_valid, op_type, inv_op, inv_asid, inv_vppn, csr_index,
    output r_e, r_g, r_asid, r_vppn, r_ps,
    input  busy, op_done, refetch_req, r_index, csr_tlbrd_we, we, w_index, w_clr
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLB maintenance op sequencer (TLBRD/TLBWR/TLBFILL/INVTLB)
//
// Purpose: owns the TLB read/write ports for WB-stage TLB instructions. Single-entry
//   ops take one EXEC cycle; INVTLB sweeps every entry, clearing E on matches.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - tlb_op_ctrl_if.slave (op request/status, TLB read and write ports)
// Build option:
//   TLB_FILL_RANDOM_EN - when defined, TLBFILL victim = low bits of a free-running
//                        cycle counter sampled at accept; otherwise round-robin pointer.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  tlb_op_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SWEEP, S_DONE} state_t;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_FILL = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [4:0]       inv_op_q, inv_op_d;
  logic [9:0]       asid_q, asid_d;
  logic [18:0]      vppn_q, vppn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fill_src;

`ifdef TLB_FILL_RANDOM_EN
  logic [IDX_W-1:0] rnd_q, rnd_d;
  assign fill_src = rnd_q;
`else
  logic [IDX_W-1:0] fill_ptr_q, fill_ptr_d;
  assign fill_src = fill_ptr_q;
`endif

  // Invalidate-match on the entry currently presented by the read port.
  logic asid_eq, va_eq, sel, match;
  always_comb begin
    asid_eq = (bus.r_asid == asid_q);
    // Large pages only carry the upper VPPN bits; 4 KiB pages compare all of them.
    va_eq   = (bus.r_ps == 6'd12) ? (bus.r_vppn == vppn_q)
                                  : (bus.r_vppn[18:9] == vppn_q[18:9]);
    case (inv_op_q)
      5'd0, 5'd1: sel = 1'b1;
      5'd2:       sel = bus.r_g;
      5'd3:       sel = !bus.r_g;
      5'd4:       sel = !bus.r_g && asid_eq;
      5'd5:       sel = !bus.r_g && asid_eq && va_eq;
      5'd6:       sel = (bus.r_g || asid_eq) && va_eq;
      default:    sel = 1'b0;
    endcase
    match = bus.r_e && sel;
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    inv_op_d   = inv_op_q;
    asid_d     = asid_q;
    vppn_d     = vppn_q;
    idx_d      = idx_q;
    fill_idx_d = fill_idx_q;
    cnt_d      = cnt_q;
`ifdef TLB_FILL_RANDOM_EN
    rnd_d      = rnd_q + 1'b1;
`else
    fill_ptr_d = fill_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          type_d     = bus.op_type;
          inv_op_d   = bus.inv_op;
          asid_d     = bus.inv_asid;
          vppn_d     = bus.inv_vppn;
          idx_d      = bus.csr_index;
          fill_idx_d = fill_src;
          cnt_d      = '0;
          if (bus.op_type == OP_INV)
            state_d = (bus.inv_op > 5'd6) ? S_DONE : S_SWEEP;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
`ifndef TLB_FILL_RANDOM_EN
        if (type_q == OP_FILL)
          fill_ptr_d = fill_ptr_q + 1'b1;
`endif
      end
      S_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(TLBNUM - 1))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      type_q     <= OP_RD;
      inv_op_q   <= '0;
      asid_q     <= '0;
      vppn_q     <= '0;
      idx_q      <= '0;
      fill_idx_q <= '0;
      cnt_q      <= '0;
`ifdef TLB_FILL_RANDOM_EN
      rnd_q      <= '0;
`else
      fill_ptr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      inv_op_q   <= inv_op_d;
      asid_q     <= asid_d;
      vppn_q     <= vppn_d;
      idx_q      <= idx_d;
      fill_idx_q <= fill_idx_d;
      cnt_q      <= cnt_d;
`ifdef TLB_FILL_RANDOM_EN
      rnd_q      <= rnd_d;
`else
      fill_ptr_q <= fill_ptr_d;
`endif
    end
  end

  // Outputs decode from registered state; only the sweep write enable also
  // depends on the read-port data for the entry being visited.
  logic exec_rd, exec_wr, exec_fill, sweeping;
  always_comb begin
    exec_rd   = (state_q == S_EXEC) && (type_q == OP_RD);
    exec_wr   = (state_q == S_EXEC) && (type_q == OP_WR);
    exec_fill = (state_q == S_EXEC) && (type_q == OP_FILL);
    sweeping  = (state_q == S_SWEEP);
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.op_done      = (state_q == S_DONE);
  assign bus.refetch_req  = (state_q == S_DONE) && (type_q != OP_RD);
  assign bus.csr_tlbrd_we = exec_rd;
  assign bus.r_index      = sweeping ? cnt_q : (exec_rd ? idx_q : '0);
  assign bus.we           = exec_wr || exec_fill || (sweeping && match);
  assign bus.w_index      = sweeping  ? cnt_q      :
                            exec_wr   ? idx_q      :
                            exec_fill ? fill_idx_q : '0;
  assign bus.w_clr        = sweeping;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - self-checking bench for tlb_op_ctrl with a TLB entry model
module tb_tlb_op_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.IDX_W(4)) bus ();
  tlb_op_ctrl #(.TLBNUM(16), .IDX_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  // TLB entry model behind the read port
  logic        mem_e    [16];
  logic        mem_g    [16];
  logic [9:0]  mem_asid [16];
  logic [18:0] mem_vppn [16];
  logic [5:0]  mem_ps   [16];

  assign bus.r_e    = mem_e[bus.r_index];
  assign bus.r_g    = mem_g[bus.r_index];
  assign bus.r_asid = mem_asid[bus.r_index];
  assign bus.r_vppn = mem_vppn[bus.r_index];
  assign bus.r_ps   = mem_ps[bus.r_index];

  always @(posedge clk) begin
    if (bus.we === 1'b1 && bus.w_clr === 1'b1) mem_e[bus.w_index] = 1'b0;
  end

  typedef struct packed { logic [3:0] idx; logic clr; } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  logic [3:0] seen_r_index;
  logic       seen_rdwe;

  // Scoreboard: every TLB write must match the next expected write
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: w_index=%0d w_clr=%0d, expected no write", bus.w_index, bus.w_clr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.w_index !== e.idx || bus.w_clr !== e.clr) begin
          errors++;
          $display("FAIL write_data: w_index=%0d w_clr=%0d, expected w_index=%0d w_clr=%0d", bus.w_index, bus.w_clr, e.idx, e.clr);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_e[i] = 1'b0; mem_g[i] = 1'b0; mem_asid[i] = '0; mem_vppn[i] = '0; mem_ps[i] = 6'd12;
    end
  endtask

  task automatic push_wr(input logic [3:0] idx, input logic clr);
    wr_t e;
    e.idx = idx; e.clr = clr;
    exp_q.push_back(e);
  endtask

  task automatic drive_op(input logic [1:0] t, input logic [4:0] iop, input logic [9:0] asid,
                          input logic [18:0] vppn, input logic [3:0] idx);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_type = t; bus.inv_op = iop;
    bus.inv_asid = asid; bus.inv_vppn = vppn; bus.csr_index = idx;
    @(posedge clk);
  endtask

  task automatic do_op(input string name, input logic [1:0] t, input logic [4:0] iop, input logic [9:0] asid,
                       input logic [18:0] vppn, input logic [3:0] idx, input int exp_lat, input logic exp_rf);
    int n;
    logic got;
    drive_op(t, iop, asid, vppn, idx);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        seen_r_index = bus.r_index;
        seen_rdwe    = bus.csr_tlbrd_we;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy: busy=%b, expected 1", name, bus.busy); end
      end
      if (bus.op_done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != exp_lat) begin errors++; $display("FAIL %s_latency: got=%b cycles=%0d, expected %0d", name, got, n, exp_lat); end
    checks++;
    if (bus.refetch_req !== exp_rf) begin errors++; $display("FAIL %s_refetch: refetch_req=%b, expected %b", name, bus.refetch_req, exp_rf); end
    bus.op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.op_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse: op_done=%b busy=%b, expected 0 0", name, bus.op_done, bus.busy);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing_writes: pending=%0d, expected 0", name, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    outs = {bus.busy, bus.op_done, bus.refetch_req, bus.csr_tlbrd_we, bus.we, bus.w_clr, bus.r_index, bus.w_index};
    checks++;
    if (outs !== 14'd0) begin errors++; $display("FAIL reset_outputs: outputs=%h, expected 0", outs); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      push_wr(4'(i % 16), 1'b0);
      do_op("fill", 2'd2, 5'd0, 10'd0, 19'd0, 4'd0, 2, 1'b1);
    end
  endtask

  task automatic test_write();
    push_wr(4'd5, 1'b0);
    do_op("wr", 2'd1, 5'd0, 10'd0, 19'd0, 4'd5, 2, 1'b1);
  endtask

  task automatic test_read();
    do_op("rd", 2'd0, 5'd0, 10'd0, 19'd0, 4'd9, 2, 1'b0);
    checks++;
    if (seen_r_index !== 4'd9 || seen_rdwe !== 1'b1) begin
      errors++; $display("FAIL rd_port: r_index=%0d csr_tlbrd_we=%b, expected 9 1", seen_r_index, seen_rdwe);
    end
  endtask

  task automatic test_inv5();
    clear_mem();
    mem_e[2] = 1'b1; mem_g[2] = 1'b0; mem_asid[2] = 10'h3; mem_vppn[2] = 19'h1234;
    mem_e[7] = 1'b1; mem_g[7] = 1'b1; mem_asid[7] = 10'h3; mem_vppn[7] = 19'h1234;
    mem_e[11] = 1'b0; mem_g[11] = 1'b0; mem_asid[11] = 10'h3; mem_vppn[11] = 19'h1234;
    push_wr(4'd2, 1'b1);
    do_op("inv5", 2'd3, 5'd5, 10'h3, 19'h1234, 4'd0, 17, 1'b1);
  endtask

  task automatic test_inv6();
    clear_mem();
    // large page: differs only in vppn[8:0], must match
    mem_e[4] = 1'b1; mem_g[4] = 1'b1; mem_asid[4] = 10'h55; mem_ps[4] = 6'd21; mem_vppn[4] = 19'h1234 ^ 19'h1AB;
    // 4 KiB page: differs in bit 0, must not match
    mem_e[6] = 1'b1; mem_g[6] = 1'b1; mem_asid[6] = 10'h55; mem_ps[6] = 6'd12; mem_vppn[6] = 19'h1235;
    push_wr(4'd4, 1'b1);
    do_op("inv6", 2'd3, 5'd6, 10'h3, 19'h1234, 4'd0, 17, 1'b1);
    checks++;
    if (mem_e[4] !== 1'b0 || mem_e[6] !== 1'b1) begin
      errors++; $display("FAIL inv6_entries: e4=%b e6=%b, expected 0 1", mem_e[4], mem_e[6]);
    end
  endtask

  task automatic test_inv9();
    for (int i = 0; i < 16; i++) mem_e[i] = 1'b1;
    do_op("inv9", 2'd3, 5'd9, 10'h0, 19'h0, 4'd0, 1, 1'b1);
  endtask

  task automatic test_reset_sweep();
    int n;
    for (int i = 0; i < 16; i++) mem_e[i] = 1'b1;
    for (int i = 0; i < 8; i++) push_wr(4'(i), 1'b1);
    drive_op(2'd3, 5'd0, 10'h0, 19'h0, 4'd0);
    n = 0;
    while (n < 40 && !(bus.busy === 1'b1 && bus.w_index === 4'd7)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL rst_sweep_reach: cycles=%0d, expected sweep index 7", n); end
    reset = 1'b1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.we, bus.w_clr, bus.op_done, bus.r_index} !== 8'd0) begin
      errors++; $display("FAIL rst_sweep_idle: busy=%b we=%b w_clr=%b op_done=%b r_index=%0d, expected all 0",
                         bus.busy, bus.we, bus.w_clr, bus.op_done, bus.r_index);
    end
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0 || mem_e[7] !== 1'b0 || mem_e[8] !== 1'b1) begin
      errors++; $display("FAIL rst_sweep_writes: pending=%0d e7=%b e8=%b, expected 0 0 1", exp_q.size(), mem_e[7], mem_e[8]);
    end
    exp_q.delete();
    push_wr(4'd3, 1'b0);
    do_op("wr_after_rst", 2'd1, 5'd0, 10'd0, 19'd0, 4'd3, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    push_wr(4'd12, 1'b0);
    do_op("b2b_wr", 2'd1, 5'd0, 10'd0, 19'd0, 4'd12, 2, 1'b1);
    do_op("b2b_rd", 2'd0, 5'd0, 10'd0, 19'd0, 4'd1, 2, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op_type = '0; bus.inv_op = '0;
    bus.inv_asid = '0; bus.inv_vppn = '0; bus.csr_index = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_fill();
    test_write();
    test_read();
    test_inv5();
    test_inv6();
    test_inv9();
    test_back_to_back();
    test_reset_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
